// File: rtl/nios_mtl_sysid_checker.sv
// Avalon-MM read initiator that fetches the system-ID and build-timestamp words and
// compares them with the expected image constants before boot is allowed to continue.
module nios_mtl_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1460114042,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIdReq  = 3'd1;
  localparam logic [2:0] StIdWait = 3'd2;
  localparam logic [2:0] StTsReq  = 3'd3;
  localparam logic [2:0] StTsWait = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(TIMEOUT_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              addr_q, addr_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              id_ok_q, id_ok_d;
  logic              ts_ok_q, ts_ok_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       id_value_q, id_value_d;
  logic [31:0]       ts_value_q, ts_value_d;

  logic in_req, in_wait, in_id, accepted, complete;

  always_comb begin
    in_req   = (state_q == StIdReq) || (state_q == StTsReq);
    in_wait  = (state_q == StIdWait) || (state_q == StTsWait);
    in_id    = (state_q == StIdReq) || (state_q == StIdWait);
    accepted = in_req && !avm_waitrequest;
    // Data may arrive in the accept cycle itself, letting the FSM skip the wait state.
    complete = (accepted && avm_readdatavalid) || (in_wait && avm_readdatavalid);
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    addr_d     = addr_q;
    read_d     = read_q;
    busy_d     = busy_q;
    done_d     = done_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StIdReq;
          timer_d    = TimerLoad;
          addr_d     = 1'b0;
          read_d     = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = '0;
          ts_value_d = '0;
        end
      end
      StIdReq, StIdWait, StTsReq, StTsWait: begin
        if (complete) begin
          if (in_id) begin
            id_value_d = avm_readdata;
            state_d    = StTsReq;
            timer_d    = TimerLoad;
            addr_d     = 1'b1;
            read_d     = 1'b1;
          end else begin
            ts_value_d = avm_readdata;
            state_d    = StDone;
            read_d     = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            id_ok_d    = (id_value_q == EXPECTED_ID);
            ts_ok_d    = (avm_readdata == EXPECTED_TS);
          end
        end else if (timer_q == '0) begin
          state_d   = StDone;
          read_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
        end else begin
          timer_d = timer_q - TimerW'(1);
          if (accepted) begin
            state_d = in_id ? StIdWait : StTsWait;
            read_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      addr_q     <= 1'b0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_nios_mtl_sysid_checker.sv
// Directed bench for nios_mtl_sysid_checker with a configurable Avalon-MM slave model.
module tb_nios_mtl_sysid_checker;

  localparam logic [31:0] ExpId = 32'd0;
  localparam logic [31:0] ExpTs = 32'd1460114042;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model configuration and state
  logic [31:0] sl_id_data = ExpId;
  logic [31:0] sl_ts_data = ExpTs;
  int          sl_wait = 0;
  int          sl_lat = 0;
  bit          sl_stuck = 1'b0;
  bit          sl_chk = 1'b0;
  int          stall_cnt = 0;
  int          dly_cnt = 0;
  int          acc_id = 0;
  int          acc_ts = 0;
  logic [31:0] pend_data = '0;
  logic        stall_addr = 1'b0;
  bit          just_acc = 1'b0;

  nios_mtl_sysid_checker #(
    .EXPECTED_ID   (ExpId),
    .EXPECTED_TS   (ExpTs),
    .TIMEOUT_CYCLES(8)
  ) u_dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .timeout          (timeout),
    .id_value         (id_value),
    .ts_value         (ts_value)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic slave_cfg(input int wt, input int lat, input bit stuck,
                           input logic [31:0] idd, input logic [31:0] tsd);
    sl_wait    = wt;
    sl_lat     = lat;
    sl_stuck   = stuck;
    sl_id_data = idd;
    sl_ts_data = tsd;
    stall_cnt  = 0;
    dly_cnt    = 0;
    acc_id     = 0;
    acc_ts     = 0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic check_pass(input string tag);
    check_eq({tag, "_id_ok"}, {31'd0, id_ok}, 32'd1);
    check_eq({tag, "_ts_ok"}, {31'd0, ts_ok}, 32'd1);
    check_eq({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_id_value"}, id_value, ExpId);
    check_eq({tag, "_ts_value"}, ts_value, ExpTs);
  endtask

  // Slave decides its response at each negedge from the master's registered outputs.
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      if (sl_chk && just_acc) check_eq("read_low_after_accept", {31'd0, avm_read}, 32'd0);
      just_acc = 1'b0;
      if (dly_cnt > 0) begin
        dly_cnt--;
        if (dly_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_data;
        end
      end
      avm_waitrequest = 1'b0;
      if (avm_read) begin
        if (sl_chk && stall_cnt > 0)
          check_eq("addr_stable", {31'd0, avm_address}, {31'd0, stall_addr});
        stall_addr = avm_address;
        if (sl_stuck || stall_cnt < sl_wait) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          stall_cnt = 0;
          if (avm_address) acc_ts++;
          else acc_id++;
          if (sl_lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = avm_address ? sl_ts_data : sl_id_data;
          end else begin
            dly_cnt   = sl_lat;
            pend_data = avm_address ? sl_ts_data : sl_id_data;
            just_acc  = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_read", {31'd0, avm_read}, 32'd0);
    check_eq("rst_id_value", id_value, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // 1: zero-wait slave, exact best-case latency
    slave_cfg(0, 0, 1'b0, ExpId, ExpTs);
    pulse_start();
    check_eq("t1_read_k1", {31'd0, avm_read}, 32'd1);
    check_eq("t1_addr_k1", {31'd0, avm_address}, 32'd0);
    check_eq("t1_busy_k1", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check_eq("t1_read_k2", {31'd0, avm_read}, 32'd1);
    check_eq("t1_addr_k2", {31'd0, avm_address}, 32'd1);
    check_eq("t1_done_k2", {31'd0, done}, 32'd0);
    @(negedge clock);
    check_eq("t1_done_k3", {31'd0, done}, 32'd1);
    check_eq("t1_read_k3", {31'd0, avm_read}, 32'd0);
    check_pass("t1");

    // 2: three stall cycles per read, data two cycles after accept
    repeat (2) @(negedge clock);
    slave_cfg(3, 2, 1'b0, ExpId, ExpTs);
    sl_chk = 1'b1;
    pulse_start();
    check_eq("t2_done_cleared", {31'd0, done}, 32'd0);
    wait_done("t2_done", 40);
    sl_chk = 1'b0;
    check_pass("t2");
    check_eq("t2_acc_id", acc_id, 32'd1);
    check_eq("t2_acc_ts", acc_ts, 32'd1);

    // 3: wrong timestamp
    repeat (2) @(negedge clock);
    slave_cfg(0, 0, 1'b0, ExpId, 32'h1234_5678);
    pulse_start();
    wait_done("t3_done", 10);
    check_eq("t3_id_ok", {31'd0, id_ok}, 32'd1);
    check_eq("t3_ts_ok", {31'd0, ts_ok}, 32'd0);
    check_eq("t3_timeout", {31'd0, timeout}, 32'd0);
    check_eq("t3_ts_value", ts_value, 32'h1234_5678);

    // 4: stuck waitrequest, timeout after 8 cycles, then recovery
    repeat (2) @(negedge clock);
    slave_cfg(0, 0, 1'b1, ExpId, ExpTs);
    pulse_start();
    check_eq("t4_read_issued", {31'd0, avm_read}, 32'd1);
    repeat (7) @(negedge clock);
    check_eq("t4_done_early", {31'd0, done}, 32'd0);
    check_eq("t4_busy_early", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check_eq("t4_done", {31'd0, done}, 32'd1);
    check_eq("t4_timeout", {31'd0, timeout}, 32'd1);
    check_eq("t4_id_ok", {31'd0, id_ok}, 32'd0);
    check_eq("t4_ts_ok", {31'd0, ts_ok}, 32'd0);
    check_eq("t4_read", {31'd0, avm_read}, 32'd0);
    slave_cfg(0, 0, 1'b0, ExpId, ExpTs);
    pulse_start();
    wait_done("t4b_done", 10);
    check_pass("t4b");

    // 5a: start pulses while busy are ignored
    repeat (2) @(negedge clock);
    slave_cfg(2, 1, 1'b0, ExpId, ExpTs);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
    end
    wait_done("t5a_done", 30);
    repeat (3) @(negedge clock);
    check_eq("t5a_acc_id", acc_id, 32'd1);
    check_eq("t5a_acc_ts", acc_ts, 32'd1);
    check_pass("t5a");

    // 5b: reset during ID_WAIT, then a late readdatavalid
    slave_cfg(0, 4, 1'b0, 32'hDEAD_BEEF, ExpTs);
    pulse_start();
    @(negedge clock);
    check_eq("t5b_in_wait_read", {31'd0, avm_read}, 32'd0);
    check_eq("t5b_in_wait_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t5b_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("t5b_rst_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check_eq("t5b_late_busy", {31'd0, busy}, 32'd0);
    check_eq("t5b_late_done", {31'd0, done}, 32'd0);
    check_eq("t5b_late_read", {31'd0, avm_read}, 32'd0);
    check_eq("t5b_late_id_value", id_value, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
